matrix_entry_writer: RTL and testbench
======================================

// Module: matrix_entry_writer
// PURPOSE
//   Board-side writer for the matrix multiplier's operand store: the input-side
//   counterpart of the seven-segment result path. User sets SW to a value and
//   presses a pushbutton; the block debounces the key, captures the value and
//   writes it to consecutive operand addresses over a valid/ready write port.
//   entry_index drives the HEX displays so the user sees which entry is next.
// PARAMETERS
//   DATA_W          8        width of one matrix element (SW value)
//   ADDR_W          4        operand-store address width
//   NUM_ENTRIES     16       entries per session; must be <= 2**ADDR_W
//   DEBOUNCE_CYCLES 500000   cycles key level must be stable (10 ms at 50 MHz)
// PORTS
//   CLOCK_50    in   1        sole clock, all logic rising-edge
//   reset       in   1        synchronous, active-high
//   key_n       in   1        raw pushbutton, active-low, asynchronous
//   data_sw     in   DATA_W   switch value, sampled on debounced press
//   start       in   1        begin a session (level, acted on in IDLE/DONE)
//   wr_en       out  1        write valid
//   wr_addr     out  ADDR_W   write address
//   wr_data     out  DATA_W   write data
//   wr_ready    in   1        store accepts write when wr_en && wr_ready
//   entry_index out  ADDR_W   index of entry awaiting a press
//   busy        out  1        high in COLLECT and WRITE
//   done        out  1        high in DONE
// BEHAVIOUR
//   Reset: state IDLE; wr_en, wr_addr, wr_data, entry_index, busy, done = 0;
//     sync flops and debounced level = 1 (released); debounce counter = 0.
//   Sync: key_n through 2 flops before any use.
//   Debounce: counter clears whenever synced == stable level; otherwise
//     increments; when it reaches DEBOUNCE_CYCLES-1 stable takes synced level
//     and counter clears. press = one-cycle pulse on stable 1->0 only.
//     Release edges never generate events; holding the key = one press.
//   FSM:
//     IDLE:    start -> COLLECT, entry_index=0. Presses ignored.
//     COLLECT: press -> wr_data<=data_sw, wr_addr<=entry_index, wr_en<=1,
//              go WRITE. start ignored.
//     WRITE:   wr_en, wr_addr, wr_data held stable until wr_en&&wr_ready
//              sampled on a clock edge. On that edge wr_en<=0 and: if
//              entry_index==NUM_ENTRIES-1 -> DONE (entry_index unchanged),
//              else entry_index++ -> COLLECT. Presses and start ignored
//              (not queued). wr_ready outside WRITE ignored.
//     DONE:    done=1; start -> COLLECT, entry_index=0, done<=0.
//   Latency: wr_en rises the cycle after the press pulse; press pulse occurs
//     2 + DEBOUNCE_CYCLES cycles after a clean key_n fall (+/-1).
//   Minimum write cost: 1 cycle in WRITE when wr_ready already high.
//   Reset mid-operation: any state -> IDLE next edge, in-flight write dropped,
//     wr_en low; a key held through reset yields no press until released and
//     re-pressed.
//   entry_index never exceeds NUM_ENTRIES-1; no wrap.
// TESTING (sim with DEBOUNCE_CYCLES=4, NUM_ENTRIES=4)
//   Bounce: start; key_n toggles every 2 cycles for 12 cycles then held low,
//     SW=0x5A -> exactly one write addr 0 data 0x5A, entry_index -> 1.
//   Fill: wr_ready=1, presses with SW=0x11,0x22,0x33,0x44 -> writes (0,0x11)
//     (1,0x22) (2,0x33) (3,0x44), done=1 and busy=0 the cycle after 4th accept.
//   Backpressure: wr_ready=0 for 6 cycles after press, second press meanwhile
//     -> wr_en/addr/data constant, one accept only, second press lost.
//   Reset in WRITE: reset for 1 cycle -> all outputs 0 next cycle; later press
//     without start -> no wr_en.
//   Hold/re-press: key low 50 cycles -> one write; release, press again ->
//     second write at next address.
//   Restart: in DONE assert start -> done=0, busy=1, entry_index=0; next write
//     to addr 0.

Source files
------------

// File: rtl/matrix_entry_writer_if.sv
// matrix_entry_writer_if: valid/ready write port into the operand store
interface matrix_entry_writer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  modport master (output wr_en, wr_addr, wr_data, input wr_ready);
  modport slave (input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/matrix_entry_writer.sv
// matrix_entry_writer: debounced pushbutton entry of switch values into consecutive operand addresses
module matrix_entry_writer #(
  parameter int DATA_W          = 8,
  parameter int ADDR_W          = 4,
  parameter int NUM_ENTRIES     = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  key_n,
  input  logic [DATA_W-1:0]     data_sw,
  input  logic                  start,
  matrix_entry_writer_if.master wr,
  output logic [ADDR_W-1:0]     entry_index,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [1:0] sync, vld;
  logic stable, armed, settle, press, en_n;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr_n, idx_n;
  logic [DATA_W-1:0] data_n;
  assign settle = sync[1] != stable && cnt == CW'(DEBOUNCE_CYCLES - 1);
  // armed only once a real released sample is seen, so a key held through reset never counts
  assign press = settle && stable && armed;
  assign busy = state == COLLECT || state == WRITE;
  assign done = state == DONE;
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync   <= 2'b11;
      vld    <= 2'b00;
      stable <= 1'b1;
      armed  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync  <= {sync[0], key_n};
      vld   <= {vld[0], 1'b1};
      armed <= armed | (vld[1] & sync[1]);
      if (sync[1] == stable || settle) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (settle) stable <= sync[1];
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      wr.wr_en    <= 1'b0;
      wr.wr_addr  <= '0;
      wr.wr_data  <= '0;
      entry_index <= '0;
    end else begin
      state       <= state_n;
      wr.wr_en    <= en_n;
      wr.wr_addr  <= addr_n;
      wr.wr_data  <= data_n;
      entry_index <= idx_n;
    end
  end
  always_comb begin
    state_n = state;
    en_n    = wr.wr_en;
    addr_n  = wr.wr_addr;
    data_n  = wr.wr_data;
    idx_n   = entry_index;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = COLLECT;
        idx_n   = '0;
      end
      COLLECT: if (press) begin
        state_n = WRITE;
        en_n    = 1'b1;
        addr_n  = entry_index;
        data_n  = data_sw;
      end
      WRITE: if (wr.wr_ready) begin
        en_n    = 1'b0;
        state_n = entry_index == ADDR_W'(NUM_ENTRIES - 1) ? DONE : COLLECT;
        idx_n   = entry_index == ADDR_W'(NUM_ENTRIES - 1) ? entry_index : entry_index + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_matrix_entry_writer.sv
// tb_matrix_entry_writer: randomized entry sessions checked against a write-queue model
module tb_matrix_entry_writer;
  localparam int DW = 8, AW = 4, NE = 4, DC = 4;
  typedef enum {M_IDLE, M_COLLECT, M_DONE} mphase_t;
  logic clk = 0, rst = 1, key_n = 1, start = 0;
  logic [DW-1:0] data_sw = '0;
  logic [AW-1:0] entry_index;
  logic busy, done;
  logic rnd_mode = 0, ready_fix = 1;
  int n_cmp = 0, n_err = 0, n_exp = 0, n_acc = 0;
  logic [AW+DW-1:0] exp_q[$];
  mphase_t m_phase = M_IDLE;
  int m_idx = 0;
  logic prev_en = 0, prev_acc = 0;
  logic [AW-1:0] prev_addr = '0, last_addr = '0;
  logic [DW-1:0] prev_data = '0, last_data = '0;
  bit p;

  matrix_entry_writer_if #(.DATA_W(DW), .ADDR_W(AW)) wr();

  matrix_entry_writer #(.DATA_W(DW), .ADDR_W(AW), .NUM_ENTRIES(NE), .DEBOUNCE_CYCLES(DC)) dut (
    .CLOCK_50(clk), .reset(rst), .key_n(key_n), .data_sw(data_sw), .start(start),
    .wr(wr), .entry_index(entry_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    wr.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      wr.wr_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  initial forever begin
    logic [AW+DW-1:0] e;
    @(negedge clk);
    if (rst) begin
      prev_en  = 0;
      prev_acc = 0;
    end else begin
      if (prev_en && !prev_acc) begin
        chk("hold_en", wr.wr_en, 1);
        chk("hold_addr", wr.wr_addr, prev_addr);
        chk("hold_data", wr.wr_data, prev_data);
      end
      if (prev_acc) begin
        if (prev_addr == AW'(NE - 1)) chk("done_after_last", {busy, done}, 2'b01);
        else begin
          chk("busy_after_acc", {busy, done}, 2'b10);
          chk("idx_after_acc", entry_index, prev_addr + 1);
        end
      end
      chk("idx_range", entry_index <= AW'(NE - 1), 1);
      chk("busy_done_excl", busy & done, 0);
      if (wr.wr_en && wr.wr_ready) begin
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", wr.wr_addr, e[DW+:AW]);
          chk("wr_data", wr.wr_data, e[DW-1:0]);
        end
        n_acc++;
        last_addr = wr.wr_addr;
        last_data = wr.wr_data;
      end
      prev_en   = wr.wr_en;
      prev_acc  = wr.wr_en && wr.wr_ready;
      prev_addr = wr.wr_addr;
      prev_data = wr.wr_data;
    end
  end

  task automatic model_reset();
    exp_q.delete();
    n_exp   = n_acc;
    m_phase = M_IDLE;
    m_idx   = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_idx"}, entry_index, m_idx);
    chk({tag, "_busy"}, busy, m_phase == M_COLLECT);
    chk({tag, "_done"}, done, m_phase == M_DONE);
  endtask

  task automatic do_start();
    start = 1;
    cyc();
    start = 0;
    if (m_phase != M_COLLECT) begin
      m_phase = M_COLLECT;
      m_idx   = 0;
    end
    check_state("start");
  endtask

  task automatic expect_press(input logic [DW-1:0] d, output bit pushed);
    pushed = m_phase == M_COLLECT;
    if (pushed) begin
      exp_q.push_back({AW'(m_idx), d});
      n_exp++;
    end
  endtask

  task automatic settle_model(input bit pushed);
    for (int i = 0; i < 300 && n_acc != n_exp; i++) cyc();
    chk("acc_count", n_acc, n_exp);
    if (pushed) begin
      if (m_idx == NE - 1) m_phase = M_DONE;
      else m_idx++;
    end
    check_state("after_press");
  endtask

  task automatic press(input logic [DW-1:0] d, input int hold);
    bit q;
    expect_press(d, q);
    data_sw = d;
    key_n = 0;
    repeat (hold) cyc();
    key_n = 1;
    repeat (DC + 4) cyc();
    settle_model(q);
  endtask

  initial begin
    logic [DW-1:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (3) cyc();
    chk("rst_wr_en", wr.wr_en, 0);
    chk("rst_wr_addr", wr.wr_addr, 0);
    chk("rst_wr_data", wr.wr_data, 0);
    chk("rst_idx", entry_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 0;
    repeat (2) cyc();
    press(8'h77, 10);
    do_start();
    expect_press(8'h5A, p);
    data_sw = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      key_n = i % 2 == 1;
      repeat (2) cyc();
    end
    key_n = 0;
    repeat (10) cyc();
    key_n = 1;
    repeat (DC + 4) cyc();
    settle_model(p);
    chk("bounce_idx", entry_index, 1);
    chk("bounce_data", last_data, 8'h5A);
    chk("bounce_addr", last_addr, 0);
    for (int i = 0; i < 3; i++) press(DW'($urandom), 10);
    do_start();
    chk("restart_pin", {done, busy, entry_index}, {1'b0, 1'b1, 4'd0});
    foreach (fill[i]) press(fill[i], 10);
    chk("fill_last_addr", last_addr, 3);
    chk("fill_last_data", last_data, 8'h44);
    chk("fill_done", {done, busy}, 2'b10);
    do_start();
    ready_fix = 0;
    expect_press(8'hA1, p);
    data_sw = 8'hA1;
    key_n = 0;
    for (int i = 0; i < 40 && !wr.wr_en; i++) cyc();
    chk("bp_en", wr.wr_en, 1);
    chk("bp_addr", wr.wr_addr, 0);
    repeat (6) cyc();
    key_n = 1;
    data_sw = 8'hB2;
    repeat (DC + 4) cyc();
    key_n = 0;
    repeat (10) cyc();
    key_n = 1;
    repeat (DC + 4) cyc();
    chk("bp_data", wr.wr_data, 8'hA1);
    chk("bp_held", wr.wr_en, 1);
    ready_fix = 1;
    settle_model(p);
    chk("bp_one", last_data, 8'hA1);
    press(8'hC3, 50);
    press(8'hD4, 10);
    chk("repress_addr", last_addr, 2);
    ready_fix = 0;
    expect_press(8'hE1, p);
    data_sw = 8'hE1;
    key_n = 0;
    for (int i = 0; i < 40 && !wr.wr_en; i++) cyc();
    chk("rw_en", wr.wr_en, 1);
    key_n = 1;
    rst = 1;
    cyc();
    chk("rw_zero", {wr.wr_en, wr.wr_addr, wr.wr_data, entry_index, busy, done}, 0);
    rst = 0;
    model_reset();
    ready_fix = 1;
    repeat (DC + 4) cyc();
    press(8'hE5, 10);
    key_n = 0;
    repeat (3) cyc();
    rst = 1;
    cyc();
    rst = 0;
    model_reset();
    do_start();
    repeat (20) cyc();
    chk("held_no_write", wr.wr_en, 0);
    chk("held_no_acc", n_acc, n_exp);
    key_n = 1;
    repeat (DC + 4) cyc();
    press(8'h3C, 10);
    chk("held_repress_addr", last_addr, 0);
    rnd_mode = 1;
    for (int i = 0; i < 14; i++) begin
      if (m_phase != M_COLLECT || $urandom_range(0, 3) == 0) do_start();
      press(DW'($urandom), $urandom_range(8, 20));
    end
    rnd_mode = 0;
    repeat (4) cyc();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
